// File: rtl/values_ram_arbiter.sv
// Two-port (CPU / loader) arbiter for a single-ported strobed RAM.
// Each transaction runs IDLE->SETUP->STROBE->CAPTURE with round-robin tie breaking.
module values_ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_done,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_we,
  output logic          ram_clk,
  input  logic [DW-1:0] ram_q,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  state_t        state;
  logic          winner;
  logic          last_served;
  logic          hold_we;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic          cpu_done_prev;
  logic          ld_done_prev;

  logic          cpu_elig;
  logic          ld_elig;
  logic          pick_ld;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // A port that just completed is masked for one IDLE cycle so its lingering req
  // cannot start a second transaction.
  always_comb begin
    cpu_elig  = cpu_req && !cpu_done_prev;
    ld_elig   = ld_req && !ld_done_prev;
    pick_ld   = ld_elig && (!cpu_elig || (last_served == PORT_CPU));
    sel_we    = pick_ld ? ld_we    : cpu_we;
    sel_addr  = pick_ld ? ld_addr  : cpu_addr;
    sel_wdata = pick_ld ? ld_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      winner        <= PORT_CPU;
      last_served   <= PORT_LD;
      hold_we       <= 1'b0;
      hold_addr     <= '0;
      hold_wdata    <= '0;
      cpu_done_prev <= 1'b0;
      ld_done_prev  <= 1'b0;
      cpu_gnt       <= 1'b0;
      ld_gnt        <= 1'b0;
      cpu_done      <= 1'b0;
      ld_done       <= 1'b0;
      cpu_rdata     <= '0;
      ld_rdata      <= '0;
      ram_addr      <= '0;
      ram_data      <= '0;
      ram_we        <= 1'b0;
      ram_clk       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      cpu_done_prev <= cpu_done;
      ld_done_prev  <= ld_done;
      case (state)
        IDLE: begin
          if (cpu_elig || ld_elig) begin
            state      <= SETUP;
            winner     <= pick_ld;
            hold_we    <= sel_we;
            hold_addr  <= sel_addr;
            hold_wdata <= sel_wdata;
            cpu_gnt    <= !pick_ld;
            ld_gnt     <= pick_ld;
            ram_addr   <= sel_addr;
            ram_data   <= sel_wdata;
            ram_we     <= sel_we;
            busy       <= 1'b1;
          end
        end
        SETUP: begin
          state   <= STROBE;
          ram_clk <= 1'b1;
        end
        STROBE: begin
          state    <= CAPTURE;
          ram_clk  <= 1'b0;
          cpu_done <= (winner == PORT_CPU);
          ld_done  <= (winner == PORT_LD);
          if (!hold_we) begin
            if (winner == PORT_LD) ld_rdata <= ram_q;
            else                   cpu_rdata <= ram_q;
          end
        end
        CAPTURE: begin
          state       <= IDLE;
          last_served <= winner;
          cpu_done    <= 1'b0;
          ld_done     <= 1'b0;
          cpu_gnt     <= 1'b0;
          ld_gnt      <= 1'b0;
          ram_addr    <= '0;
          ram_data    <= '0;
          ram_we      <= 1'b0;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

  gnt_onehot: assert property (@(posedge clk) disable iff (!reset)
    !(cpu_gnt && ld_gnt));
  strobe_in_strobe: assert property (@(posedge clk) disable iff (!reset)
    ram_clk |-> (state == STROBE));
  cpu_done_pulse: assert property (@(posedge clk) disable iff (!reset)
    cpu_done |=> !cpu_done);
  ld_done_pulse: assert property (@(posedge clk) disable iff (!reset)
    ld_done |=> !ld_done);

endmodule

// File: tb/tb_values_ram_arbiter.sv
// Bench for values_ram_arbiter: behavioural RAM, directed timing scenarios and
// a scoreboard of expected completions checked on every done pulse.
module tb_values_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int W  = AW + DW + 2;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, ld_req, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata;
  logic          cpu_gnt, cpu_done, ld_gnt, ld_done;
  logic [DW-1:0] cpu_rdata, ld_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_we, ram_clk, busy;
  logic [1:0]    fsm_state;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] model_mem [256];
  logic [W-1:0]  exp_q [$];
  logic [W-1:0]  mon_e;
  logic [DW-1:0] mon_rd;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  values_ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_clk(ram_clk),
    .ram_q(ram_q), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural RAM: asynchronous read, write on a strobed edge
  assign ram_q = mem[ram_addr];
  always @(posedge clk) if (ram_clk && ram_we) mem[ram_addr] <= ram_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every done pulse must match the front of exp_q
  always @(negedge clk) begin
    checks++;
    if (cpu_gnt && ld_gnt) begin
      errors++;
      $display("FAIL gnt_onehot: cpu_gnt=%b ld_gnt=%b, required at most one high", cpu_gnt, ld_gnt);
    end
    if (cpu_done || ld_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: cpu_done=%b ld_done=%b, required no completion", cpu_done, ld_done);
      end else begin
        mon_e = exp_q.pop_front();
        mon_rd = mon_e[W-1] ? ld_rdata : cpu_rdata;
        if ((cpu_done && ld_done) || (ld_done !== mon_e[W-1])) begin
          errors++;
          $display("FAIL sb_port: cpu_done=%b ld_done=%b, required port %0d", cpu_done, ld_done, mon_e[W-1]);
        end else if (!mon_e[W-2] && (mon_rd !== mon_e[DW-1:0])) begin
          errors++;
          $display("FAIL sb_rdata: addr=%h got %h required %h", mon_e[AW+DW-1:DW], mon_rd, mon_e[DW-1:0]);
        end else if (mon_e[W-2] && (mem[mon_e[AW+DW-1:DW]] !== mon_e[DW-1:0])) begin
          errors++;
          $display("FAIL sb_wdata: addr=%h got %h required %h", mon_e[AW+DW-1:DW],
                   mem[mon_e[AW+DW-1:DW]], mon_e[DW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (we) model_mem[a] = d;
    exp_q.push_back({p, we, a, (we ? d : model_mem[a])});
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_ld(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_cpu(0, 0, 0, 0);
    drive_ld(0, 0, 0, 0);
    repeat (3) tick();
    checks++;
    if ({busy, cpu_gnt, ld_gnt, cpu_done, ld_done, ram_clk, ram_we} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, cpu_gnt, ld_gnt, cpu_done, ld_done, ram_clk, ram_we});
    end
    checks++;
    if ({ram_addr, ram_data, cpu_rdata, ld_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {ram_addr, ram_data, cpu_rdata, ld_rdata});
    end
    checks++;
    if (fsm_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d required 0", fsm_state);
    end
    reset = 1'b1;
  endtask

  task automatic test_cpu_write();
    drive_cpu(1, 1, 8'h10, 8'hA5);
    push(0, 1, 8'h10, 8'hA5);
    tick();
    checks++;
    if ({cpu_gnt, ld_gnt, ram_we, ram_clk, busy} !== 5'b10101) begin
      errors++; $display("FAIL wr_setup_ctrl: got %b required 10101", {cpu_gnt, ld_gnt, ram_we, ram_clk, busy});
    end
    checks++;
    if ({ram_addr, ram_data} !== 16'h10A5) begin
      errors++; $display("FAIL wr_setup_bus: got %h required 10a5", {ram_addr, ram_data});
    end
    cpu_addr = 8'hEE;
    cpu_wdata = 8'hFF;
    tick();
    checks++;
    if ({ram_clk, ram_we, ld_gnt, ram_addr, ram_data} !== {3'b110, 16'h10A5}) begin
      errors++; $display("FAIL wr_strobe: got %h required %h", {ram_clk, ram_we, ld_gnt, ram_addr, ram_data},
                         {3'b110, 16'h10A5});
    end
    tick();
    checks++;
    if ({cpu_done, cpu_gnt, ram_clk, ram_we, ld_gnt, ram_addr} !== {5'b11010, 8'h10}) begin
      errors++; $display("FAIL wr_capture: got %h required %h", {cpu_done, cpu_gnt, ram_clk, ram_we, ld_gnt, ram_addr},
                         {5'b11010, 8'h10});
    end
    drive_cpu(0, 0, 0, 0);
    tick();
    checks++;
    if ({busy, cpu_gnt, cpu_done, ram_we, ram_addr, ram_data} !== '0) begin
      errors++; $display("FAIL wr_idle: got %h required 0", {busy, cpu_gnt, cpu_done, ram_we, ram_addr, ram_data});
    end
  endtask

  task automatic test_ld_read();
    logic [DW-1:0] prev_cpu;
    prev_cpu = cpu_rdata;
    drive_ld(1, 0, 8'h20, 8'h00);
    push(1, 0, 8'h20, 8'h00);
    tick();
    checks++;
    if ({ld_gnt, cpu_gnt, ram_we, ram_addr} !== {3'b100, 8'h20}) begin
      errors++; $display("FAIL rd_setup: got %h required %h", {ld_gnt, cpu_gnt, ram_we, ram_addr}, {3'b100, 8'h20});
    end
    tick();
    checks++;
    if (ram_clk !== 1'b1) begin
      errors++; $display("FAIL rd_strobe: ram_clk got %b required 1", ram_clk);
    end
    tick();
    checks++;
    if ({ld_done, cpu_done, ld_rdata} !== {2'b10, 8'h3C}) begin
      errors++; $display("FAIL rd_capture: got %h required %h", {ld_done, cpu_done, ld_rdata}, {2'b10, 8'h3C});
    end
    checks++;
    if (cpu_rdata !== prev_cpu) begin
      errors++; $display("FAIL rd_cpu_rdata_kept: got %h required %h", cpu_rdata, prev_cpu);
    end
    drive_ld(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_lingering();
    drive_cpu(1, 0, 8'h10, 8'h00);
    push(0, 0, 8'h10, 8'h00);
    repeat (3) tick();
    checks++;
    if (cpu_done !== 1'b1) begin
      errors++; $display("FAIL linger_done: got %b required 1", cpu_done);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL linger_idle1: busy got %b required 0", busy);
    end
    tick();
    checks++;
    if ({busy, cpu_gnt} !== 2'b00) begin
      errors++; $display("FAIL linger_no_retrigger: busy/gnt got %b required 00", {busy, cpu_gnt});
    end
    drive_cpu(0, 0, 0, 0);
    tick();
  endtask

  task automatic test_simultaneous();
    int done_t[4];
    int n;
    int s;
    test_reset();
    drive_cpu(1, 0, 8'h30, 8'h00);
    drive_ld(1, 0, 8'h31, 8'h00);
    push(0, 0, 8'h30, 8'h00);
    push(1, 0, 8'h31, 8'h00);
    push(0, 0, 8'h30, 8'h00);
    push(1, 0, 8'h31, 8'h00);
    s = cyc;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      tick();
      if (cpu_done || ld_done) begin
        done_t[n] = cyc;
        n++;
      end
      if (n == 4) begin
        drive_cpu(0, 0, 0, 0);
        drive_ld(0, 0, 0, 0);
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL sim_timeout: got %0d completions required 4", n);
      drive_cpu(0, 0, 0, 0);
      drive_ld(0, 0, 0, 0);
    end else begin
      checks++;
      if (done_t[0] - s != 3) begin
        errors++; $display("FAIL sim_first_latency: got %0d required 3", done_t[0] - s);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (done_t[i] - done_t[i-1] != 4) begin
          errors++; $display("FAIL sim_spacing%0d: got %0d required 4", i, done_t[i] - done_t[i-1]);
        end
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_op();
    drive_cpu(1, 1, 8'h40, 8'h77);
    repeat (2) tick();
    checks++;
    if (ram_clk !== 1'b1) begin
      errors++; $display("FAIL mid_strobe: ram_clk got %b required 1", ram_clk);
    end
    reset = 1'b0;
    drive_ld(1, 0, 8'h20, 8'h00);
    tick();
    checks++;
    if ({fsm_state, ram_clk, cpu_gnt, ld_gnt, cpu_done, ld_done, busy} !== 8'b0) begin
      errors++; $display("FAIL mid_reset: got %b required 00000000",
                         {fsm_state, ram_clk, cpu_gnt, ld_gnt, cpu_done, ld_done, busy});
    end
    reset = 1'b1;
    drive_cpu(0, 0, 0, 0);
    push(1, 0, 8'h20, 8'h00);
    tick();
    checks++;
    if ({ld_gnt, cpu_gnt} !== 2'b10) begin
      errors++; $display("FAIL mid_first_grant: ld/cpu gnt got %b required 10", {ld_gnt, cpu_gnt});
    end
    repeat (2) tick();
    checks++;
    if ({ld_done, ld_rdata} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL mid_ld_done: got %h required %h", {ld_done, ld_rdata}, {1'b1, 8'h3C});
    end
    drive_ld(0, 0, 0, 0);
    repeat (2) tick();
  endtask

  task automatic test_busy_arrival();
    drive_cpu(1, 1, 8'h50, 8'h5A);
    push(0, 1, 8'h50, 8'h5A);
    push(1, 0, 8'h10, 8'h00);
    tick();
    drive_ld(1, 0, 8'h10, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_done) break;
    end
    checks++;
    if (cpu_done !== 1'b1) begin
      errors++; $display("FAIL busy_cpu_done: got %b required 1", cpu_done);
    end
    drive_cpu(0, 0, 0, 0);
    tick();
    checks++;
    if (ld_gnt !== 1'b0) begin
      errors++; $display("FAIL busy_gnt_early: ld_gnt got %b required 0", ld_gnt);
    end
    tick();
    checks++;
    if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL busy_gnt_rise: ld_gnt got %b required 1", ld_gnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ld_done) break;
    end
    checks++;
    if (ld_done !== 1'b1) begin
      errors++; $display("FAIL busy_ld_done: got %b required 1", ld_done);
    end
    drive_ld(0, 0, 0, 0);
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic p, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int s;
    for (int k = 0; k < 24; k++) begin
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(128, 255));
      d  = 8'($urandom_range(0, 255));
      push(p, we, a, d);
      if (p) drive_ld(1, we, a, d);
      else   drive_cpu(1, we, a, d);
      s = cyc;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (cpu_done || ld_done) break;
      end
      checks++;
      if (cyc - s != 3) begin
        errors++; $display("FAIL rand_latency%0d: got %0d cycles required 3", k, cyc - s);
      end
      drive_cpu(0, 0, 0, 0);
      drive_ld(0, 0, 0, 0);
      repeat (2 + $urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 7 + 3);
      model_mem[i] = 8'(i * 7 + 3);
    end
    mem[8'h20] = 8'h3C; model_mem[8'h20] = 8'h3C;
    mem[8'h30] = 8'h11; model_mem[8'h30] = 8'h11;
    mem[8'h31] = 8'h22; model_mem[8'h31] = 8'h22;
    test_reset();
    test_cpu_write();
    test_ld_read();
    test_lingering();
    test_simultaneous();
    test_reset_mid_op();
    test_busy_arrival();
    test_random();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
